// File: rtl/battle_turn_control_pkg.sv
// Shared battle definitions: turn FSM state encoding, target side encoding,
// default wait-state timeout and the saturating turn counter helper.
package battle_turn_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_DAMAGE = 4'd2,
        ST_SETTLE = 4'd3,
        ST_DECR   = 4'd4,
        ST_DRAW   = 4'd5,
        ST_CHECK  = 4'd6,
        ST_OVER   = 4'd7,
        ST_FAULT  = 4'd8
    } state_t;

    typedef enum logic {
        SIDE_MEOWTH = 1'b0,
        SIDE_PLAYER = 1'b1
    } side_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 65535;
    localparam logic [7:0]  TURN_COUNT_MAX         = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == TURN_COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/battle_turn_control_wait_timer.sv
// 16-bit wait-state counter: cleared by i_clear, counts while i_run, and
// flags o_expired once the count has reached LIMIT.
module wait_timer #(
    parameter logic [15:0] LIMIT = 16'd65534
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    logic [15:0] r_count;

    // Saturates so a stalled run can never wrap back below LIMIT.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expired = (r_count >= LIMIT);

endmodule

// File: rtl/battle_turn_control.sv
// Turn sequencer for the damage datapath: steps HP load, damage, settle,
// x-decrement and white-bar draw, then alternates the target side.
module battle_turn_control
    import battle_turn_control_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       done_decrement,
    input  logic       done_damage,
    input  logic       game_over,
    output logic       enable_HP_calc,
    output logic       enable_DMG_calc,
    output logic       enable_decrement_control,
    output logic       enable_draw_decrease,
    output logic       target,
    output logic       busy,
    output logic       turn_done,
    output logic       game_end,
    output logic       fault,
    output logic [7:0] turn_count,
    output logic [3:0] dbg_state
);

    localparam logic [15:0] LP_TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    side_t      r_target;
    logic       r_go_seen;
    logic       r_en_hp;
    logic       r_en_dmg;
    logic       r_en_decr;
    logic       r_en_draw;
    logic       r_busy;
    logic       r_turn_done;
    logic       r_game_end;
    logic       r_fault;
    logic [7:0] r_turn_count;
    logic       w_in_wait;
    logic       w_timer_clear;
    logic       w_expired;

    // Done handshake: the datapath holds its done high until we drop the
    // matching enable; the done is accepted on the edge it is sampled high in
    // its own wait state, the enable falls on that edge, and the datapath then
    // clears the done. A done outside its wait state is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (go) w_next = ST_LOAD;
            ST_LOAD:   w_next = ST_DAMAGE;
            ST_DAMAGE: w_next = ST_SETTLE;
            ST_SETTLE: w_next = ST_DECR;
            ST_DECR: begin
                if (done_decrement)  w_next = ST_DRAW;
                else if (w_expired)  w_next = ST_FAULT;
            end
            ST_DRAW: begin
                if (done_damage)     w_next = ST_CHECK;
                else if (w_expired)  w_next = ST_FAULT;
            end
            ST_CHECK:  w_next = r_go_seen ? ST_OVER : ST_IDLE;
            ST_OVER:   w_next = ST_OVER;
            ST_FAULT:  w_next = ST_FAULT;
            default:   w_next = ST_FAULT;
        endcase
    end

    assign w_in_wait     = (r_state == ST_DECR) || (r_state == ST_DRAW);
    assign w_timer_clear = !w_in_wait || ((r_state == ST_DECR) && done_decrement);

    wait_timer #(
        .LIMIT (LP_TIMER_LIMIT)
    ) u_wait_timer (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_clear   (w_timer_clear),
        .i_run     (w_in_wait),
        .o_expired (w_expired)
    );

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_target     <= SIDE_MEOWTH;
            r_go_seen    <= 1'b0;
            r_en_hp      <= 1'b0;
            r_en_dmg     <= 1'b0;
            r_en_decr    <= 1'b0;
            r_en_draw    <= 1'b0;
            r_busy       <= 1'b0;
            r_turn_done  <= 1'b0;
            r_game_end   <= 1'b0;
            r_fault      <= 1'b0;
            r_turn_count <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_en_hp     <= (w_next == ST_LOAD);
            r_en_dmg    <= (w_next == ST_DAMAGE);
            r_en_decr   <= (w_next == ST_DECR);
            r_en_draw   <= (w_next == ST_DRAW);
            r_busy      <= (w_next != ST_IDLE);
            r_game_end  <= (w_next == ST_OVER);
            r_fault     <= (w_next == ST_FAULT);
            r_turn_done <= (r_state == ST_CHECK) && (w_next == ST_IDLE);

            if ((r_state == ST_IDLE) && (w_next == ST_LOAD)) begin
                r_go_seen <= 1'b0;
            end else if ((r_state != ST_IDLE) && game_over) begin
                r_go_seen <= 1'b1;
            end

            if ((r_state == ST_CHECK) && (w_next == ST_IDLE)) begin
                r_target     <= (r_target == SIDE_MEOWTH) ? SIDE_PLAYER : SIDE_MEOWTH;
                r_turn_count <= sat_inc8(r_turn_count);
            end
        end
    end

    assign enable_HP_calc           = r_en_hp;
    assign enable_DMG_calc          = r_en_dmg;
    assign enable_decrement_control = r_en_decr;
    assign enable_draw_decrease     = r_en_draw;
    assign target                   = r_target;
    assign busy                     = r_busy;
    assign turn_done                = r_turn_done;
    assign game_end                 = r_game_end;
    assign fault                    = r_fault;
    assign turn_count               = r_turn_count;
    assign dbg_state                = r_state;

endmodule

// File: tb/tb_battle_turn_control.sv
// Bench for battle_turn_control: two instances (default and 8-cycle timeout)
// share stimulus and are checked every cycle against a turn-level model.
module tb_battle_turn_control;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0;
    logic done_decrement = 1'b0;
    logic done_damage = 1'b0;
    logic game_over = 1'b0;

    logic       a_hp, a_dmg, a_decr, a_draw, a_tgt, a_busy, a_td, a_ge, a_flt;
    logic [7:0] a_cnt;
    logic [3:0] a_dbg;
    logic       b_hp, b_dmg, b_decr, b_draw, b_tgt, b_busy, b_td, b_ge, b_flt;
    logic [7:0] b_cnt;
    logic [3:0] b_dbg;

    int checks = 0;
    int failures = 0;

    battle_turn_control dut_a (
        .clock(clock), .reset(reset), .go(go),
        .done_decrement(done_decrement), .done_damage(done_damage), .game_over(game_over),
        .enable_HP_calc(a_hp), .enable_DMG_calc(a_dmg),
        .enable_decrement_control(a_decr), .enable_draw_decrease(a_draw),
        .target(a_tgt), .busy(a_busy), .turn_done(a_td), .game_end(a_ge),
        .fault(a_flt), .turn_count(a_cnt), .dbg_state(a_dbg)
    );

    battle_turn_control #(.TIMEOUT_CYCLES(8)) dut_b (
        .clock(clock), .reset(reset), .go(go),
        .done_decrement(done_decrement), .done_damage(done_damage), .game_over(game_over),
        .enable_HP_calc(b_hp), .enable_DMG_calc(b_dmg),
        .enable_decrement_control(b_decr), .enable_draw_decrease(b_draw),
        .target(b_tgt), .busy(b_busy), .turn_done(b_td), .game_end(b_ge),
        .fault(b_flt), .turn_count(b_cnt), .dbg_state(b_dbg)
    );

    wire [16:0] obs_a = {a_hp, a_dmg, a_decr, a_draw, a_tgt, a_busy, a_td, a_ge, a_flt, a_cnt};
    wire [16:0] obs_b = {b_hp, b_dmg, b_decr, b_draw, b_tgt, b_busy, b_td, b_ge, b_flt, b_cnt};

    initial forever #5 clock = ~clock;

    // ---------------- turn-level reference model ----------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_DAMAGE = 2, P_SETTLE = 3, P_DECR = 4;
    localparam int P_DRAW = 5, P_CHECK = 6, P_OVER = 7, P_FAULT = 8;

    int m_phase [2];
    int m_wait  [2];
    int m_count [2];
    int m_limit [2] = '{65535, 8};
    bit m_seen  [2];
    bit m_tgt   [2];
    bit m_td    [2];

    task automatic model_reset(input int i);
        m_phase[i] = P_IDLE;
        m_wait[i]  = 0;
        m_count[i] = 0;
        m_seen[i]  = 1'b0;
        m_tgt[i]   = 1'b0;
        m_td[i]    = 1'b0;
    endtask

    task automatic model_step(input int i);
        bit old_seen;
        int p;
        old_seen = m_seen[i];
        p = m_phase[i];
        m_td[i] = 1'b0;
        if (p != P_IDLE && game_over) m_seen[i] = 1'b1;
        case (p)
            P_IDLE: if (go) begin m_phase[i] = P_LOAD; m_seen[i] = 1'b0; end
            P_LOAD:   m_phase[i] = P_DAMAGE;
            P_DAMAGE: m_phase[i] = P_SETTLE;
            P_SETTLE: begin m_phase[i] = P_DECR; m_wait[i] = 0; end
            P_DECR: begin
                if (done_decrement) begin m_phase[i] = P_DRAW; m_wait[i] = 0; end
                else if (m_wait[i] >= m_limit[i] - 1) m_phase[i] = P_FAULT;
                else m_wait[i]++;
            end
            P_DRAW: begin
                if (done_damage) m_phase[i] = P_CHECK;
                else if (m_wait[i] >= m_limit[i] - 1) m_phase[i] = P_FAULT;
                else m_wait[i]++;
            end
            P_CHECK: begin
                if (old_seen) begin
                    m_phase[i] = P_OVER;
                end else begin
                    m_phase[i] = P_IDLE;
                    m_tgt[i]   = ~m_tgt[i];
                    m_count[i] = (m_count[i] < 255) ? m_count[i] + 1 : 255;
                    m_td[i]    = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [16:0] expect_vec(input int i);
        int p;
        p = m_phase[i];
        return {p == P_LOAD, p == P_DAMAGE, p == P_DECR, p == P_DRAW, m_tgt[i],
                p != P_IDLE, m_td[i], p == P_OVER, p == P_FAULT, 8'(m_count[i])};
    endfunction

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) model_reset(i);
            else       model_step(i);
        end
    end

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("cycle_dut_a", obs_a, expect_vec(0));
        chk("cycle_dut_b", obs_b, expect_vec(1));
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        go = 1'b0; done_decrement = 1'b0; done_damage = 1'b0; game_over = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int seen_td;
        int k;

        // Test 1: reference turn timing with go at edge 5
        do_reset();
        chk("t1_reset_state", obs_a, 17'd0);
        repeat (4) tick();
        go = 1'b1; tick(); go = 1'b0;
        chk("t1_hp_strobe", 17'({a_hp, a_dmg}), 17'b10);
        tick();
        chk("t1_dmg_strobe", 17'({a_hp, a_dmg}), 17'b01);
        tick();
        chk("t1_settle", 17'({a_hp, a_dmg, a_decr, a_draw, a_busy}), 17'b00001);
        tick();
        chk("t1_decr_on", 17'(a_decr), 17'd1);
        repeat (11) tick();
        done_decrement = 1'b1; tick(); done_decrement = 1'b0;
        chk("t1_draw_on", 17'({a_decr, a_draw}), 17'b01);
        repeat (19) tick();
        done_damage = 1'b1; tick(); done_damage = 1'b0;
        chk("t1_check_no_td", 17'({a_td, a_draw, a_busy}), 17'b001);
        tick();
        chk("t1_turn_done", 17'({a_td, a_tgt, a_busy}), 17'b110);
        chk("t1_count", 17'(a_cnt), 17'd1);
        tick();
        chk("t1_td_one_cycle", 17'(a_td), 17'd0);

        // Test 2: two back-to-back minimum turns with go held high
        do_reset();
        go = 1'b1; done_decrement = 1'b1; done_damage = 1'b1;
        seen_td = 0;
        for (k = 1; k <= 40; k++) begin
            tick();
            if (a_td) begin
                seen_td++;
                if (seen_td == 1) begin
                    chk("t2_first_edge", 17'(k), 17'd7);
                    chk("t2_target_1", 17'(a_tgt), 17'd1);
                end else begin
                    chk("t2_second_edge", 17'(k), 17'd14);
                    chk("t2_target_0", 17'(a_tgt), 17'd0);
                    go = 1'b0;
                    break;
                end
            end
        end
        chk("t2_turns_seen", 17'(seen_td), 17'd2);
        chk("t2_count", 17'(a_cnt), 17'd2);
        done_decrement = 1'b0; done_damage = 1'b0;
        repeat (3) tick();
        chk("t2_stays_idle", 17'({a_busy, a_hp}), 17'b00);

        // Test 3: game_over pulse during DECR ends the game
        do_reset();
        go = 1'b1; tick(); go = 1'b0;
        repeat (3) tick();
        game_over = 1'b1; tick(); game_over = 1'b0;
        go = 1'b1;
        done_decrement = 1'b1; tick(); done_decrement = 1'b0;
        done_damage = 1'b1; tick(); done_damage = 1'b0;
        tick();
        chk("t3_over", 17'({a_ge, a_td, a_busy, a_flt}), 17'b0110 ^ 17'b1100);
        repeat (5) tick();
        chk("t3_go_ignored", 17'({a_hp, a_dmg, a_decr, a_draw, a_ge}), 17'b00001);
        chk("t3_count", 17'(a_cnt), 17'd0);
        go = 1'b0;

        // Test 4: no done_decrement, 8-cycle timeout instance faults
        do_reset();
        go = 1'b1; tick(); go = 1'b0;
        repeat (3) tick();
        repeat (7) tick();
        chk("t4_not_yet", 17'({b_flt, b_decr}), 17'b01);
        tick();
        chk("t4_fault", 17'({b_flt, b_hp, b_dmg, b_decr, b_draw}), 17'b10000);
        chk("t4_default_waits", 17'({a_flt, a_decr}), 17'b01);

        // Test 5: done_damage in the same cycle as the timeout wins
        do_reset();
        go = 1'b1; tick(); go = 1'b0;
        repeat (3) tick();
        done_decrement = 1'b1; tick(); done_decrement = 1'b0;
        repeat (7) tick();
        done_damage = 1'b1; tick(); done_damage = 1'b0;
        chk("t5_check", 17'({b_flt, b_busy, b_draw}), 17'b010);
        tick();
        chk("t5_done_wins", 17'({b_flt, b_td, b_tgt}), 17'b011);

        // Test 6: asynchronous reset in DRAW
        do_reset();
        done_decrement = 1'b1; done_damage = 1'b1;
        go = 1'b1; tick(); go = 1'b0;
        repeat (6) tick();
        chk("t6_pre_turn", 17'({a_tgt, a_cnt}), 17'({1'b1, 8'd1}));
        done_damage = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        repeat (4) tick();
        done_decrement = 1'b0;
        chk("t6_in_draw", 17'(a_draw), 17'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_drop", 17'({a_draw, a_tgt, a_busy, a_cnt}), 17'd0);
        tick();
        reset = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        chk("t6_restart_load", 17'(a_hp), 17'd1);

        // Randomized traffic, checked every cycle by the compare process
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            go             = ($urandom_range(0, 99) < 30);
            done_decrement = ($urandom_range(0, 99) < 25);
            done_damage    = ($urandom_range(0, 99) < 25);
            game_over      = ($urandom_range(0, 99) < 1);
            if ($urandom_range(0, 999) < 15) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
